fir_product_reducer: RTL
========================

// Module: fir_product_reducer
// PURPOSE
//   Consumer end of the FIR multiplier bank: takes the TAP signed products of one output sample,
//   sums them in a registered adder tree, then rounds and saturates to the audio sample width.
//   Sits between the Booth multiplier array and the audio output path of the symmetric FIR.
//   Streaming, no backpressure: one product vector per clock at most.
// PARAMETERS
//   TAP     51  number of products per sample (any value >= 2)
//   PROD_W  42  width of each signed product
//   OUT_W   24  width of the signed output sample
//   SHIFT   15  fractional bits of the coefficients; right shift applied after the sum
// PORTS
//   clk         in   1                clock
//   rst         in   1                synchronous, active-high reset
//   in_valid    in   1                product vector valid this cycle
//   product     in   PROD_W x [0:TAP-1]  signed products, sampled when in_valid=1
//   sat_clr     in   1                clears sat_sticky
//   out_valid   out  1                out_sample valid (single-cycle per sample)
//   out_sample  out  OUT_W            signed, rounded, saturated sum
//   out_sat     out  1                pulses with out_valid when this sample saturated
//   sat_sticky  out  1                set by any saturation, held until sat_clr or rst
// BEHAVIOUR
//   - LEVELS = $clog2(TAP) (6 for 51); ACC_W = PROD_W + LEVELS (48). All adds are sign-extended to ACC_W.
//   - Tree: one register stage per level. Each stage adds adjacent pairs (2k, 2k+1).
//     An odd last element passes through registered and unchanged. Level L has ceil(N/2) outputs.
//   - Final stage: r = (sum + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf, arithmetic shift.
//     If r > 2^(OUT_W-1)-1, output 0x7FFFFF and set out_sat. If r < -2^(OUT_W-1), output 0x800000
//     and set out_sat. The rounding add is done at ACC_W+1 bits, so it never wraps.
//   - Latency: fixed LEVELS+1 cycles (7). An input accepted at cycle t gives out_valid=1 at t+7.
//     Throughput is 1 sample/cycle, in order, and back-to-back inputs give back-to-back outputs.
//   - A valid shift register of depth LEVELS+1 runs parallel to the data.
//     A data stage loads only when its valid bit loads 1; otherwise it holds.
//   - out_sample and out_sat hold their last values while out_valid=0. out_sat is qualified by out_valid.
//   - sat_sticky: set if (out_valid & out_sat), else cleared if sat_clr.
//     If set and sat_clr occur in the same cycle, set wins.
//   - Reset values: out_valid=0, out_sample=0, out_sat=0, sat_sticky=0, all valid bits=0.
//     Data registers are also cleared to 0.
//   - Reset mid-operation: every in-flight sample is discarded and no out_valid appears for it.
//     An input accepted on the first cycle after rst deasserts appears exactly 7 cycles later.
//   - in_valid=1 during rst is ignored.
//   - Pure function of inputs: no state carries between samples except sat_sticky.
// STRUCTURE
//   - fir_pkg (shared with the multiplier/pre-adder blocks):
//     TAP, PROD_W, OUT_W, SHIFT defaults; localparams LEVELS and ACC_W;
//     typedef acc_t (logic signed [ACC_W-1:0]); function sat_round(acc_t) returning {sat, sample}.
//   - Sub-module fir_add_stage #(N_IN, W): one registered pairwise-add level with a valid in/out.
//     The top instantiates LEVELS of these in a generate loop, plus the round/saturate register stage.
//   - Total width per level grows 1 bit; the top sign-extends products to ACC_W before level 0.
// TESTING
//   1. product[0]=32768 (1<<15), others 0, one in_valid pulse at t0 -> out_valid only at t0+7,
//      out_sample=1, out_sat=0.
//   2. Rounding, one vector each, product[0] only:
//      16384 -> 1; 16383 -> 0; -16384 -> 0; -16385 -> -1; -32768 -> -1.
//   3. Saturation: all 51 products = 2^40 -> out_sample=0x7FFFFF, out_sat=1, sat_sticky=1.
//      All = -2^40 -> 0x800000. sat_sticky stays 1 across a following non-saturating sample.
//   4. Burst: in_valid high 10 cycles, vector k has product[i]=k<<15 for all i ->
//      10 consecutive out_valid cycles starting t0+7, out_sample=51*k for k=1..10, in order.
//   5. Reset mid-burst: rst high for 1 cycle during cycle 3 of a 10-cycle burst ->
//      outputs for samples 1-3 never appear. out_valid=0 and out_sample=0 until the first
//      post-reset input emerges 7 cycles after acceptance.
//   6. sat_clr asserted the same cycle a saturating sample exits -> sat_sticky=1.
//      sat_clr on the next cycle with no saturation -> sat_sticky=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and the round/saturate helper used by the
// multiplier, pre-adder and product-reducer blocks.
package fir_pkg;
   localparam int TAP    = 51;
   localparam int PROD_W = 42;
   localparam int OUT_W  = 24;
   localparam int SHIFT  = 15;
   localparam int LEVELS = $clog2(TAP);
   localparam int ACC_W  = PROD_W + LEVELS;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [OUT_W-1:0] sample_t;
   typedef struct packed {
      logic    sat;
      sample_t sample;
   } sat_sample_t;

   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2 ** (SHIFT - 1));
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN  = -(ACC_W+1)'(2 ** (OUT_W - 1));

   // Element count entering tree level lvl.
   function automatic int level_n(input int lvl);
      return (TAP + (1 << lvl) - 1) >> lvl;
   endfunction

   // Round half toward +inf at one extra bit so the bias add cannot wrap.
   function automatic sat_sample_t sat_round(input acc_t sum);
      logic signed [ACC_W:0] rnd;
      sat_sample_t           res;
      rnd = ((ACC_W+1)'(sum) + RND_HALF) >>> SHIFT;
      if (rnd > SAT_MAX) begin
         res.sat    = 1'b1;
         res.sample = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (rnd < SAT_MIN) begin
         res.sat    = 1'b1;
         res.sample = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         res.sat    = 1'b0;
         res.sample = sample_t'(rnd);
      end
      return res;
   endfunction
endpackage

// File: rtl/fir_add_stage.sv
// One registered level of the product adder tree: sums adjacent pairs and
// forwards an odd trailing element unchanged.
module fir_add_stage #(
   parameter  int N_IN  = 2,
   parameter  int W     = 8,
   localparam int N_OUT = (N_IN + 1) / 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   input  logic [N_IN-1:0][W-1:0]    data_i,
   output logic                      valid_o,
   output logic [N_OUT-1:0][W-1:0]   data_o
);
   logic [N_OUT-1:0][W-1:0] data_d;
   logic [N_OUT-1:0][W-1:0] data_q;
   logic                    valid_q;

   for (genvar k = 0; k < N_OUT; k++) begin : g_pair
      if (2 * k + 1 < N_IN) begin : g_add
         assign data_d[k] = data_i[2*k] + data_i[2*k+1];
      end else begin : g_pass
         assign data_d[k] = data_i[2*k];
      end
   end

   // Data only advances with a valid sample so idle cycles leave it untouched.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= data_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/fir_product_reducer.sv
// Sums the per-tap products of one output sample through a pipelined adder
// tree, then rounds and saturates to the audio sample width.
module fir_product_reducer
   import fir_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   input  logic [TAP-1:0][PROD_W-1:0]   product_i,
   input  logic                         sat_clr_i,
   output logic                         out_valid_o,
   output logic [OUT_W-1:0]             out_sample_o,
   output logic                         out_sat_o,
   output logic                         sat_sticky_o
);
   logic [TAP-1:0][ACC_W-1:0] ext_s;
   acc_t                      sum_s;
   logic                      sum_valid_s;
   sat_sample_t               rs_s;

   logic                      out_valid_d,  out_valid_q;
   logic [OUT_W-1:0]          out_sample_d, out_sample_q;
   logic                      out_sat_d,    out_sat_q;
   logic                      sat_sticky_d, sat_sticky_q;

   for (genvar i = 0; i < TAP; i++) begin : g_ext
      assign ext_s[i] = {{LEVELS{product_i[i][PROD_W-1]}}, product_i[i]};
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N_IN  = level_n(l);
      localparam int N_OUT = level_n(l + 1);
      logic [N_IN-1:0][ACC_W-1:0]  din_s;
      logic                        vin_s;
      logic [N_OUT-1:0][ACC_W-1:0] dout_s;
      logic                        vout_s;
      if (l == 0) begin : g_first
         assign din_s = ext_s;
         assign vin_s = in_valid_i;
      end else begin : g_next
         assign din_s = g_lvl[l-1].dout_s;
         assign vin_s = g_lvl[l-1].vout_s;
      end
      fir_add_stage #(.N_IN(N_IN), .W(ACC_W)) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .valid_i (vin_s),
         .data_i  (din_s),
         .valid_o (vout_s),
         .data_o  (dout_s)
      );
   end

   assign sum_s       = acc_t'(g_lvl[LEVELS-1].dout_s[0]);
   assign sum_valid_s = g_lvl[LEVELS-1].vout_s;
   assign rs_s        = sat_round(sum_s);

   // Output stage next-state; a saturation report beats a same-cycle clear.
   always_comb begin
      out_valid_d  = sum_valid_s;
      out_sample_d = out_sample_q;
      out_sat_d    = out_sat_q;
      if (sum_valid_s) begin
         out_sample_d = rs_s.sample;
         out_sat_d    = rs_s.sat;
      end else begin
         out_sample_d = out_sample_q;
         out_sat_d    = out_sat_q;
      end
      if (out_valid_q && out_sat_q) begin
         sat_sticky_d = 1'b1;
      end else if (sat_clr_i) begin
         sat_sticky_d = 1'b0;
      end else begin
         sat_sticky_d = sat_sticky_q;
      end
   end

   // Round/saturate register stage and sticky flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_sat_q    <= 1'b0;
         sat_sticky_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         out_sat_q    <= out_sat_d;
         sat_sticky_q <= sat_sticky_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_sample_o = out_sample_q;
   assign out_sat_o    = out_sat_q;
   assign sat_sticky_o = sat_sticky_q;
endmodule
